sdram_emulator: RTL
===================

Name: sdram_emulator

Overview:
- Synthesizable SDRAM device emulator. It is the responder on the same 16-bit SDRAM command bus our SDRAM controller drives.
- Decodes CS/RAS/CAS/WE commands and tracks open rows per bank.
- Honours the mode register (CAS latency, burst length) and serves read/write bursts from on-chip block RAM.
- Used for controller verification and for boards without SDRAM; it also flags protocol violations.

Parameters:
- MEM_ADDR_BITS, 12, log2 of emulated 16-bit words; linear address {BA,row,col} truncated to these LSBs.
- COL_BITS, 9, column bits taken from SDRAM_A during READ/WRITE.
- ROW_BITS, 13, row bits taken from SDRAM_A during ACTIVE.

Ports:
- clk  in  1  Single clock. All emulator logic updates on the rising edge.
- reset  in  1  Synchronous, active-high.
- SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn  in  1 each  Command; CSn=1 means unselected, treated as NOP.
- SDRAM_CKE  in  1  Low: all commands ignored and burst counters frozen.
- SDRAM_A  in  13  Row, column or mode value; A10 is the auto/all-bank flag.
- SDRAM_BA  in  2  Bank select.
- SDRAM_DQM  in  2  Write byte masks; bit1 = upper byte.
- SDRAM_DQ_i  in  16  Write data from the controller.
- SDRAM_DQ_o  out  16  Read data.
- SDRAM_DQ_oe  out  1  High while read data is driven.
- err  out  1  Sticky protocol-error flag.
- err_code  out  3  Code of the most recent error.
- refresh_count  out  16  REFRESH commands accepted; saturates at 16'hFFFF.

Behaviour:
- Reset:
  - All banks closed; mode = CL2, BL2, sequential.
  - Burst and CL pipelines flushed.
  - Outputs: SDRAM_DQ_o=0, SDRAM_DQ_oe=0, err=0, err_code=0, refresh_count=0.
  - RAM contents retained. Reset mid-burst aborts the burst with no further writes.
- Command sampling: on each rising edge where CKE=1.
- ACTIVE:
  - Bank BA closed: open it, latch row = A[ROW_BITS-1:0].
  - Bank BA already open: err_code=1, state unchanged.
- READ:
  - Requires bank BA open, else err_code=2 and the command is ignored.
  - Latch col = A[COL_BITS-1:0]; A10 ignored.
  - Word k of the burst is driven on SDRAM_DQ_o, with SDRAM_DQ_oe=1, from rising edge R+CL-1+k to rising edge R+CL+k, where R is the command-sampling edge.
  - CL=2 with BL2 means the controller samples word0 at R+2 and word1 at R+3.
  - SDRAM_DQ_oe drops at the edge after the last word.
- WRITE:
  - Requires bank BA open, else err_code=3 and the command is ignored.
  - Word0 is taken from SDRAM_DQ_i on the command edge; word k on edge W+k.
  - A byte is written only when its DQM bit is 0.
- Burst addressing:
  - Column for word k = (col & ~(BL-1)) | ((col+k) & (BL-1)), i.e. sequential wrap inside the BL-aligned block.
  - Linear address = {BA,row,col_k}[MEM_ADDR_BITS-1:0].
- PRECHARGE:
  - A10=1 closes all banks; otherwise closes bank BA.
  - Precharging a closed bank is legal.
- REFRESH:
  - All banks must be closed, else err_code=4.
  - On success, increments refresh_count.
- LOADMODE:
  - All banks must be closed, else err_code=4.
  - Mode = A[9:0]: BL = A[2:0] (0,1,2,3 → 1,2,4,8), A3 burst type, CL = A[6:4].
  - CL not in {2,3}, BL code >3, or A3=1 (interleaved): err_code=5, mode unchanged.
- BURST TERMINATE: ends any active burst immediately; SDRAM_DQ_oe=0 next edge.
- Simultaneous/overlap events:
  - New READ during a read burst: old burst truncated, new burst's CL pipeline starts.
  - WRITE during a read burst: read aborted, SDRAM_DQ_oe=0 on the same edge, write proceeds.
  - READ during a write burst: write stops after the current word.
  - PRECHARGE of the bursting bank: burst ends after the current word.
- Any error sets err=1 (sticky until reset) and overwrites err_code.

Optional Feature:
- Macro SDRAM_EMU_TIMING_CHECK_EN.
- When defined:
  - Per-bank counters enforce tRCD=2: READ/WRITE fewer than 2 cycles after ACTIVE gives err_code=6.
  - tRP=2: ACTIVE or REFRESH fewer than 2 cycles after PRECHARGE of that bank gives err_code=7.
  - The command still executes.
- When undefined: no timing counters; codes 6/7 are never produced.

Decomposition:
- Package sdram_pkg holds:
  - command encodings as 4-bit {CSn,RASn,CASn,WEn}: NOP=0111, ACTIVE=0011, READ=0101, WRITE=0100, TERMINATE=0110, PRECHARGE=0010, REFRESH=0001, LOADMODE=0000;
  - error codes 1-7;
  - mode-field bit positions.
- Sub-module sdram_emu_mem: single-port 16-bit RAM, 2 byte enables, registered read, depth 2^MEM_ADDR_BITS.

Test Plan:
- Reset, PRECHARGE A10=1, 2×REFRESH, LOADMODE A=0x021 → refresh_count=2, err=0, mode CL2/BL2.
- ACTIVE BA=0 row=5; WRITE col=4 with data 0x1234 then 0xABCD, DQM=00; PRECHARGE; ACTIVE; READ col=4 → DQ_o=0x1234 at R+2 and 0xABCD at R+3; oe high for exactly 2 cycles.
- WRITE col=7 (BL2) with 0x1111, 0x2222 → reads back col7=0x1111, col6=0x2222 (wrap).
- WRITE 0xBEEF with DQM=10 over 0x0000 → reads 0x00EF.
- READ with no open bank → err=1, err_code=2, oe stays 0; second ACTIVE to an open bank → err_code=1.
- LOADMODE A=0x031 (CL3, BL2) → word0 at R+3; reset asserted mid-burst → oe=0 next edge, banks closed, RAM data intact.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device emulator.
//
// Contents:
//   cmd_e        4-bit command encoding {CSn,RASn,CASn,WEn}
//   err_e        protocol error codes reported on err_code
//   MODE_*       bit positions of the fields in the mode register value
//   AP_BIT       address bit carrying the auto-precharge / all-bank flag
//   decode_cmd   turns the raw command pins into a cmd_e (CSn high -> NOP)
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_LOADMODE  = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_TERMINATE = 4'b0110,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ACT_OPEN   = 3'd1,
    ERR_RD_CLOSED  = 3'd2,
    ERR_WR_CLOSED  = 3'd3,
    ERR_BANKS_OPEN = 3'd4,
    ERR_BAD_MODE   = 3'd5,
    ERR_TRCD       = 3'd6,
    ERR_TRP        = 3'd7
  } err_e;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_BT_BIT = 3;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int AP_BIT      = 10;
  localparam int NUM_BANKS   = 4;

  localparam logic [1:0] BL_CODE_RESET = 2'd1;  // BL2

  localparam int T_RCD = 2;
  localparam int T_RP  = 2;

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic wen);
    if (csn) return CMD_NOP;
    return cmd_e'({1'b0, rasn, casn, wen});
  endfunction

endpackage

// File: rtl/sdram_emulator_if.sv
// SDRAM command/data bus between a controller (master) and the emulator
// (slave).
//
// Signals:
//   SDRAM_CSn/RASn/CASn/WEn  command strobes, active low
//   SDRAM_CKE                clock enable; low freezes the device
//   SDRAM_A[12:0]            row / column / mode value, A10 = all-bank flag
//   SDRAM_BA[1:0]            bank select
//   SDRAM_DQM[1:0]           write byte masks, bit1 = upper byte
//   SDRAM_DQ_i[15:0]         write data from the controller
//   SDRAM_DQ_o[15:0]         read data from the device
//   SDRAM_DQ_oe              high while the device drives read data
interface sdram_emulator_if;
  logic        SDRAM_CSn;
  logic        SDRAM_RASn;
  logic        SDRAM_CASn;
  logic        SDRAM_WEn;
  logic        SDRAM_CKE;
  logic [12:0] SDRAM_A;
  logic [1:0]  SDRAM_BA;
  logic [1:0]  SDRAM_DQM;
  logic [15:0] SDRAM_DQ_i;
  logic [15:0] SDRAM_DQ_o;
  logic        SDRAM_DQ_oe;

  modport master (
    output SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn, SDRAM_CKE,
           SDRAM_A, SDRAM_BA, SDRAM_DQM, SDRAM_DQ_i,
    input  SDRAM_DQ_o, SDRAM_DQ_oe
  );

  modport slave (
    input  SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn, SDRAM_CKE,
           SDRAM_A, SDRAM_BA, SDRAM_DQM, SDRAM_DQ_i,
    output SDRAM_DQ_o, SDRAM_DQ_oe
  );
endinterface

// File: rtl/sdram_emu_mem.sv
// Single-port 16-bit storage array backing the emulated SDRAM.
//
// Ports:
//   clk          clock
//   en           access enable for this cycle
//   we           1 = write, 0 = read (registered, data on rdata next cycle)
//   be[1:0]      byte enables for writes, bit1 = upper byte
//   addr         word address
//   wdata        write data
//   rdata        registered read data (holds when not reading)
// Contents have no reset and survive the emulator reset.
module sdram_emu_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sdram_emulator.sv
// SDRAM device emulator: responds to the controller's SDRAM command bus,
// tracks open rows per bank, honours CAS latency / burst length from the
// mode register and serves bursts from on-chip RAM. Protocol violations
// raise a sticky err flag with the latest code on err_code.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   bus            sdram_emulator_if.slave (command, address, data)
//   err            sticky protocol-error flag
//   err_code[2:0]  code of the most recent error
//   refresh_count  accepted REFRESH commands, saturating
//
// Build option: define SDRAM_EMU_TIMING_CHECK_EN to add per-bank tRCD/tRP
// checking (codes 6/7); without it those codes never occur.
module sdram_emulator
  import sdram_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 12,
  parameter int COL_BITS      = 9,
  parameter int ROW_BITS      = 13
) (
  input  logic            clk,
  input  logic            reset,
  sdram_emulator_if.slave bus,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [15:0]     refresh_count
);

  // Sequential wrap of the column inside the BL-aligned block.
  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] col,
                                                    input logic [2:0] k,
                                                    input logic [1:0] bl_code);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'((4'd1 << bl_code) - 4'd1);
    return (col & ~mask) | ((col + COL_BITS'(k)) & mask);
  endfunction

  function automatic logic [MEM_ADDR_BITS-1:0] lin_addr(input logic [1:0] b,
                                                        input logic [ROW_BITS-1:0] r,
                                                        input logic [COL_BITS-1:0] c);
    return MEM_ADDR_BITS'({b, r, c});
  endfunction

  cmd_e                cmd;
  logic [1:0]          ba;
  logic [12:0]         a;
  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_BITS-1:0] bank_row [NUM_BANKS];
  logic                sel_open;
  logic                any_open;
  logic [NUM_BANKS-1:0] pre_mask;
  logic                act_ok, rd_ok, wr_ok, pre_cmd, ref_ok, lm_ok, term, mode_ok;

  logic [1:0]          bl_code;
  logic                cl3;
  logic [2:0]          bl_last;

  logic                rd_run;
  logic [1:0]          rd_delay;
  logic [2:0]          rd_k;
  logic [1:0]          rd_bank;
  logic [ROW_BITS-1:0] rd_row;
  logic [COL_BITS-1:0] rd_col;
  logic                dq_oe;

  logic                wr_run;
  logic [2:0]          wr_k;
  logic [1:0]          wr_bank;
  logic [ROW_BITS-1:0] wr_row;
  logic [COL_BITS-1:0] wr_col;

  logic                rd_issue, wr_cont;
  logic                mem_en, mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [15:0]         mem_rdata;

  logic                err_hit;
  err_e                err_val;

  // CKE low turns every command into NOP and freezes the burst engines.
  assign cmd = bus.SDRAM_CKE ? decode_cmd(bus.SDRAM_CSn, bus.SDRAM_RASn,
                                          bus.SDRAM_CASn, bus.SDRAM_WEn)
                             : CMD_NOP;
  assign ba       = bus.SDRAM_BA;
  assign a        = bus.SDRAM_A;
  assign sel_open = bank_open[ba];
  assign any_open = |bank_open;
  assign pre_mask = a[AP_BIT] ? {NUM_BANKS{1'b1}} : NUM_BANKS'(1) << ba;
  assign mode_ok  = (a[MODE_CL_MSB:MODE_CL_LSB] inside {3'd2, 3'd3}) &&
                    !a[MODE_BL_MSB] && !a[MODE_BT_BIT];

  assign act_ok  = (cmd == CMD_ACTIVE) && !sel_open;
  assign rd_ok   = (cmd == CMD_READ) && sel_open;
  assign wr_ok   = (cmd == CMD_WRITE) && sel_open;
  assign pre_cmd = (cmd == CMD_PRECHARGE);
  assign ref_ok  = (cmd == CMD_REFRESH) && !any_open;
  assign lm_ok   = (cmd == CMD_LOADMODE) && !any_open && mode_ok;
  assign term    = (cmd == CMD_TERMINATE);

  assign bl_last = 3'((4'd1 << bl_code) - 4'd1);

  // A new READ/WRITE or TERMINATE preempts the read word due this edge; a
  // PRECHARGE of the bank still lets the current word out.
  assign rd_issue = bus.SDRAM_CKE && rd_run && (rd_delay == 2'd1) &&
                    !(rd_ok || wr_ok || term);
  // The write word on a stopping command's edge is not data, so it is dropped.
  assign wr_cont  = bus.SDRAM_CKE && wr_run &&
                    !(rd_ok || wr_ok || term || (pre_cmd && pre_mask[wr_bank]));

`ifdef SDRAM_EMU_TIMING_CHECK_EN
  logic [1:0] trcd_cnt [NUM_BANKS];
  logic [1:0] trp_cnt  [NUM_BANKS];
  logic       trp_any;

  always_comb begin
    trp_any = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) trp_any = trp_any | (trp_cnt[b] != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        trcd_cnt[b] <= 2'd0;
        trp_cnt[b]  <= 2'd0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (act_ok && (ba == 2'(b))) trcd_cnt[b] <= 2'(T_RCD - 1);
        else if (trcd_cnt[b] != 2'd0) trcd_cnt[b] <= trcd_cnt[b] - 2'd1;
        if (pre_cmd && pre_mask[b]) trp_cnt[b] <= 2'(T_RP - 1);
        else if (trp_cnt[b] != 2'd0) trp_cnt[b] <= trp_cnt[b] - 2'd1;
      end
    end
  end
`endif

  // Functional errors take priority over timing errors on the same command.
  always_comb begin
    err_hit = 1'b0;
    err_val = ERR_NONE;
    case (cmd)
      CMD_ACTIVE:   if (sel_open) begin err_hit = 1'b1; err_val = ERR_ACT_OPEN;   end
      CMD_READ:     if (!sel_open) begin err_hit = 1'b1; err_val = ERR_RD_CLOSED; end
      CMD_WRITE:    if (!sel_open) begin err_hit = 1'b1; err_val = ERR_WR_CLOSED; end
      CMD_REFRESH:  if (any_open) begin err_hit = 1'b1; err_val = ERR_BANKS_OPEN; end
      CMD_LOADMODE: begin
        if (any_open) begin
          err_hit = 1'b1;
          err_val = ERR_BANKS_OPEN;
        end else if (!mode_ok) begin
          err_hit = 1'b1;
          err_val = ERR_BAD_MODE;
        end
      end
      default: ;
    endcase
`ifdef SDRAM_EMU_TIMING_CHECK_EN
    if (!err_hit) begin
      if ((rd_ok || wr_ok) && (trcd_cnt[ba] != 2'd0)) begin
        err_hit = 1'b1;
        err_val = ERR_TRCD;
      end else if ((act_ok && (trp_cnt[ba] != 2'd0)) || (ref_ok && trp_any)) begin
        err_hit = 1'b1;
        err_val = ERR_TRP;
      end
    end
`endif
  end

  // RAM port: a WRITE command uses the live pins, otherwise the burst engines.
  always_comb begin
    mem_en = !reset && (wr_ok || wr_cont || rd_issue);
    mem_we = wr_ok || wr_cont;
    if (wr_ok)
      mem_addr = lin_addr(ba, bank_row[ba], a[COL_BITS-1:0]);
    else if (wr_cont)
      mem_addr = lin_addr(wr_bank, wr_row, burst_col(wr_col, wr_k, bl_code));
    else
      mem_addr = lin_addr(rd_bank, rd_row, burst_col(rd_col, rd_k, bl_code));
  end

  sdram_emu_mem #(
    .ADDR_W (MEM_ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .be    (~bus.SDRAM_DQM),
    .addr  (mem_addr),
    .wdata (bus.SDRAM_DQ_i),
    .rdata (mem_rdata)
  );

  assign bus.SDRAM_DQ_o  = dq_oe ? mem_rdata : 16'h0000;
  assign bus.SDRAM_DQ_oe = dq_oe;

  // Control state: bank status, mode, burst engines, error and refresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open     <= '0;
      bl_code       <= BL_CODE_RESET;
      cl3           <= 1'b0;
      rd_run        <= 1'b0;
      rd_delay      <= 2'd0;
      rd_k          <= 3'd0;
      dq_oe         <= 1'b0;
      wr_run        <= 1'b0;
      wr_k          <= 3'd0;
      err           <= 1'b0;
      err_code      <= 3'd0;
      refresh_count <= 16'h0000;
    end else begin
      if (err_hit) begin
        err      <= 1'b1;
        err_code <= err_val;
      end
      if (act_ok) bank_open[ba] <= 1'b1;
      if (pre_cmd) bank_open <= bank_open & ~pre_mask;
      if (ref_ok && (refresh_count != 16'hFFFF)) refresh_count <= refresh_count + 16'd1;
      if (lm_ok) begin
        bl_code <= a[1:0];
        cl3     <= a[MODE_CL_LSB];
      end

      if (bus.SDRAM_CKE) begin
        // Read engine: count down CL-1 edges, then one word per edge.
        if (rd_ok) begin
          rd_run   <= 1'b1;
          rd_delay <= cl3 ? 2'd2 : 2'd1;
          rd_k     <= 3'd0;
          dq_oe    <= 1'b0;
        end else if (wr_ok || term) begin
          rd_run <= 1'b0;
          dq_oe  <= 1'b0;
        end else if (rd_run) begin
          if (rd_delay != 2'd1) begin
            rd_delay <= rd_delay - 2'd1;
          end else begin
            dq_oe <= 1'b1;
            rd_k  <= rd_k + 3'd1;
            if (rd_k == bl_last) rd_run <= 1'b0;
          end
          if (pre_cmd && pre_mask[rd_bank]) rd_run <= 1'b0;
        end else begin
          dq_oe <= 1'b0;
        end

        // Write engine: word0 on the command edge, then one word per edge.
        if (wr_ok) begin
          wr_run <= (bl_code != 2'd0);
          wr_k   <= 3'd1;
        end else if (wr_cont) begin
          wr_k <= wr_k + 3'd1;
          if (wr_k == bl_last) wr_run <= 1'b0;
        end else if (rd_ok || term || (pre_cmd && pre_mask[wr_bank])) begin
          wr_run <= 1'b0;
        end
      end
    end
  end

  // Row and burst address registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (act_ok) bank_row[ba] <= a[ROW_BITS-1:0];
    if (rd_ok) begin
      rd_bank <= ba;
      rd_row  <= bank_row[ba];
      rd_col  <= a[COL_BITS-1:0];
    end
    if (wr_ok) begin
      wr_bank <= ba;
      wr_row  <= bank_row[ba];
      wr_col  <= a[COL_BITS-1:0];
    end
  end

endmodule
